// File: rtl/instr_pkg.sv
// Shared instruction-format definitions for the fetch queue and the decode stage.
// Field layout follows the base RV32 R/I/S encoding.
package instr_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int OPCODE_LSB = 0;
    localparam int RD_LSB     = 7;
    localparam int FUNCT3_LSB = 12;
    localparam int RS1_LSB    = 15;
    localparam int RS2_LSB    = 20;
    localparam int FUNCT7_LSB = 25;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } instr_fields_t;

    function automatic instr_fields_t split_fields(input logic [31:0] word);
        instr_fields_t f;
        f.funct7 = word[FUNCT7_LSB +: 7];
        f.rs2    = word[RS2_LSB    +: 5];
        f.rs1    = word[RS1_LSB    +: 5];
        f.funct3 = word[FUNCT3_LSB +: 3];
        f.rd     = word[RD_LSB     +: 5];
        f.opcode = word[OPCODE_LSB +: 7];
        return f;
    endfunction

endpackage

// File: rtl/instr_fields.sv
// Combinational split of an instruction word into its register/opcode fields.
// Shared between the instruction queue head and the decode stage.
module instr_fields
    import instr_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] instr,
    output instr_fields_t   fields
);

    assign fields = split_fields(instr[31:0]);

endmodule

// File: rtl/instr_queue.sv
// DEPTH-entry FIFO of {pc, instruction} pairs between fetch and decode, with flush.
// The head entry is presented with its decoded fields; an empty queue presents a NOP.
module instr_queue
    import instr_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [XLEN-1:0]        in_instr,
    input  logic [XLEN-1:0]        in_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_instr,
    output logic [XLEN-1:0]        out_pc,
    output logic [4:0]             rs2,
    output logic [4:0]             rs1,
    output logic [4:0]             rd,
    output logic [2:0]             funct3,
    output logic [6:0]             funct7,
    output logic [6:0]             opcode,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] instr_mem_r [DEPTH];
    logic [XLEN-1:0] pc_mem_r    [DEPTH];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic [CW-1:0]   count_nxt_s;
    logic            out_valid_r;
    logic            in_ready_r;
    logic            push_s;
    logic            pop_s;
    instr_fields_t   head_fields_s;

    assign push_s = in_valid & in_ready_r;
    assign pop_s  = out_valid_r & out_ready;

    // Occupancy after this cycle's handshakes (flush/reset handled in the register).
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointers, occupancy and registered handshake flags; reset beats flush beats push/pop.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_r    <= {PW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
            count_r     <= {CW{1'b0}};
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            count_r     <= count_nxt_s;
            out_valid_r <= (count_nxt_s != {CW{1'b0}});
            in_ready_r  <= (count_nxt_s != CW'(DEPTH));
        end
    end

    // Storage arrays carry no reset; only entries behind valid pointers are ever shown.
    always_ff @(posedge clk) begin
        if (push_s && !reset && !flush) begin
            instr_mem_r[wr_ptr_r] <= in_instr;
            pc_mem_r[wr_ptr_r]    <= in_pc;
        end
    end

    assign out_instr = out_valid_r ? instr_mem_r[rd_ptr_r] : XLEN'(NOP_INSTR);
    assign out_pc    = out_valid_r ? pc_mem_r[rd_ptr_r]    : {XLEN{1'b0}};
    assign out_valid = out_valid_r;
    assign in_ready  = in_ready_r;
    assign count     = count_r;

    instr_fields #(.XLEN(XLEN)) u_fields (
        .instr  (out_instr),
        .fields (head_fields_s)
    );

    assign rs2    = head_fields_s.rs2;
    assign rs1    = head_fields_s.rs1;
    assign rd     = head_fields_s.rd;
    assign funct3 = head_fields_s.funct3;
    assign funct7 = head_fields_s.funct7;
    assign opcode = head_fields_s.opcode;

endmodule

// File: tb/tb_instr_queue.sv
// Directed self-checking bench for instr_queue (DEPTH=4): vector table plus
// hand-written sequences for streaming, flush and reset corner cases.
module tb_instr_queue;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] in_instr, in_pc;
    logic        in_ready, out_valid;
    logic [31:0] out_instr, out_pc;
    logic [4:0]  rs2, rs1, rd;
    logic [2:0]  funct3;
    logic [6:0]  funct7, opcode;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_queue #(.XLEN(32), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .rs2(rs2), .rs1(rs1), .rd(rd), .funct3(funct3), .funct7(funct7), .opcode(opcode),
        .count(count)
    );

    typedef struct {
        logic        rst;
        logic        fl;
        logic        iv;
        logic        ordy;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        ev;
        logic        er;
        logic [31:0] ei;
        logic [31:0] ep;
        logic [2:0]  ec;
    } vec_t;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] W1  = 32'h0050_0093;
    localparam logic [31:0] W2  = 32'h0020_8133;
    localparam logic [31:0] W3  = 32'h0020_81b3;
    localparam logic [31:0] W4  = 32'h4020_8233;
    localparam logic [31:0] W5  = 32'h0000_0213;

    vec_t vecs [10];

    function automatic vec_t mk(input logic rst, input logic fl, input logic iv, input logic ordy,
                                input logic [31:0] instr, input logic [31:0] pc,
                                input logic ev, input logic er, input logic [31:0] ei,
                                input logic [31:0] ep, input logic [2:0] ec);
        vec_t v;
        v.rst = rst; v.fl = fl; v.iv = iv; v.ordy = ordy; v.instr = instr; v.pc = pc;
        v.ev = ev; v.er = er; v.ei = ei; v.ep = ep; v.ec = ec;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic fl, input logic iv, input logic ordy,
                         input logic [31:0] instr, input logic [31:0] pc);
        reset = rst; flush = fl; in_valid = iv; out_ready = ordy; in_instr = instr; in_pc = pc;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string tag, input logic ev, input logic er,
                                input logic [31:0] ei, input logic [31:0] ep, input logic [2:0] ec);
        logic [31:0] e;
        e = ei;
        chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ev});
        chk({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, er});
        chk({tag, ".out_instr"}, out_instr, ei);
        chk({tag, ".out_pc"},    out_pc, ep);
        chk({tag, ".count"},     {29'd0, count}, {29'd0, ec});
        chk({tag, ".fields"}, {funct7, rs2, rs1, funct3, rd, opcode},
            {e[31:25], e[24:20], e[19:15], e[14:12], e[11:7], e[6:0]});
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = 32'd0; in_pc = 32'd0;

        // Fill, hold while full, pop-while-full, delayed accept, flush.
        vecs[0] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0,  1'b0, 1'b1, NOP, 32'h0, 3'd0);
        vecs[1] = mk(1'b0, 1'b0, 1'b1, 1'b0, W1,    32'h0,  1'b1, 1'b1, W1,  32'h0, 3'd1);
        vecs[2] = mk(1'b0, 1'b0, 1'b1, 1'b0, W2,    32'h4,  1'b1, 1'b1, W1,  32'h0, 3'd2);
        vecs[3] = mk(1'b0, 1'b0, 1'b1, 1'b0, W3,    32'h8,  1'b1, 1'b1, W1,  32'h0, 3'd3);
        vecs[4] = mk(1'b0, 1'b0, 1'b1, 1'b0, W4,    32'hc,  1'b1, 1'b0, W1,  32'h0, 3'd4);
        vecs[5] = mk(1'b0, 1'b0, 1'b1, 1'b0, W5,    32'h10, 1'b1, 1'b0, W1,  32'h0, 3'd4);
        vecs[6] = mk(1'b0, 1'b0, 1'b1, 1'b1, W5,    32'h10, 1'b1, 1'b1, W2,  32'h4, 3'd3);
        vecs[7] = mk(1'b0, 1'b0, 1'b1, 1'b0, W5,    32'h10, 1'b1, 1'b0, W2,  32'h4, 3'd4);
        vecs[8] = mk(1'b0, 1'b1, 1'b1, 1'b1, W1,    32'h20, 1'b0, 1'b1, NOP, 32'h0, 3'd0);
        vecs[9] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0,  1'b0, 1'b1, NOP, 32'h0, 3'd0);

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].ordy, vecs[i].instr, vecs[i].pc);
            expect_state($sformatf("vec%0d", i), vecs[i].ev, vecs[i].er, vecs[i].ei,
                         vecs[i].ep, vecs[i].ec);
        end

        // First push decodes to addi x1, x0, 5.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, W1, 32'h0);
        chk("t1.rd",     {27'd0, rd},     32'd1);
        chk("t1.rs1",    {27'd0, rs1},    32'd0);
        chk("t1.opcode", {25'd0, opcode}, 32'h13);
        chk("t1.count",  {29'd0, count},  32'd1);

        // Continuous stream across pointer wrap: head tracks the latest push.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h1000_0000 + 32'(i), 32'(i * 4));
            expect_state($sformatf("stream%0d", i), 1'b1, 1'b1,
                         32'h1000_0000 + 32'(i), 32'(i * 4), 3'd1);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
        expect_state("stream_drain", 1'b0, 1'b1, NOP, 32'h0, 3'd0);

        // Flush at count=3 with push and pop asserted drops everything.
        drive(1'b0, 1'b0, 1'b1, 1'b0, W2, 32'h40);
        drive(1'b0, 1'b0, 1'b1, 1'b0, W3, 32'h44);
        drive(1'b0, 1'b0, 1'b1, 1'b0, W4, 32'h48);
        chk("t5.pre_count", {29'd0, count}, 32'd3);
        drive(1'b0, 1'b1, 1'b1, 1'b1, W5, 32'h4c);
        expect_state("t5.flush", 1'b0, 1'b1, NOP, 32'h0, 3'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        expect_state("t5.idle", 1'b0, 1'b1, NOP, 32'h0, 3'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, W1, 32'h80);
        expect_state("t5.repush", 1'b1, 1'b1, W1, 32'h80, 3'd1);

        // Reset at count=2 with a push active, then no stale entry after one push.
        drive(1'b0, 1'b0, 1'b1, 1'b0, W2, 32'h84);
        chk("t6.pre_count", {29'd0, count}, 32'd2);
        drive(1'b1, 1'b0, 1'b1, 1'b0, W3, 32'h88);
        expect_state("t6.reset", 1'b0, 1'b1, NOP, 32'h0, 3'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, W4, 32'h100);
        expect_state("t6.push", 1'b1, 1'b1, W4, 32'h100, 3'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
        expect_state("t6.pop", 1'b0, 1'b1, NOP, 32'h0, 3'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
